// File: rtl/token_decoder.sv
// token_decoder: turns one Snappy token-queue entry per cycle into a literal
// or copy command held in a registered output slot.
//
// Handshakes:
//   upstream   - in_rdreq pops the queue head on the same rising edge; the
//                next head shows up on in_valid/in_data one cycle later.
//   downstream - a token transfers on every rising edge where
//                tok_valid & tok_ready; while tok_valid is high and tok_ready
//                is low, every tok_* field is held constant. A pop in the
//                same cycle as a transfer refills the slot with no bubble.
//
// A malformed tag (zero copy offset, oversized copy4 offset, or a literal
// longer than 65536 bytes) parks the block in ERR until rst_n is applied.
// state_dbg mirrors the FSM state (0 = RUN, 1 = ERR).
module token_decoder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [143:0] in_data,
  input  logic [15:0]  in_position,
  input  logic [16:0]  in_address,
  input  logic [1:0]   in_garbage,
  input  logic         in_lit_flag,
  input  logic         in_valid,
  output logic         in_rdreq,
  output logic         tok_valid,
  input  logic         tok_ready,
  output logic         tok_is_copy,
  output logic [16:0]  tok_length,
  output logic [15:0]  tok_offset,
  output logic [15:0]  tok_lit_pos,
  output logic [16:0]  tok_address,
  output logic [31:0]  tok_count,
  output logic [15:0]  drop_count,
  output logic         err,
  output logic         state_dbg
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  // Registered state
  state_t      state_q,       state_d;
  logic        tok_valid_q,   tok_valid_d;
  logic        tok_is_copy_q, tok_is_copy_d;
  logic [16:0] tok_length_q,  tok_length_d;
  logic [15:0] tok_offset_q,  tok_offset_d;
  logic [15:0] tok_lit_pos_q, tok_lit_pos_d;
  logic [16:0] tok_address_q, tok_address_d;
  logic [31:0] tok_count_q,   tok_count_d;
  logic [15:0] drop_count_q,  drop_count_d;

  // Window bytes the decoder actually looks at
  logic [7:0] b0, b1, b2, b3, b4;
  logic [5:0] tag_n;

  assign b0    = in_data[143:136];
  assign b1    = in_data[135:128];
  assign b2    = in_data[127:120];
  assign b3    = in_data[119:112];
  assign b4    = in_data[111:104];
  assign tag_n = b0[7:2];

  // Bytes 5..17 and the garbage bits carry nothing this block needs.
  logic unused_inputs;
  assign unused_inputs = ^{in_garbage, in_data[103:0]};

  // Decoder results for the current queue head
  logic        dec_is_copy;
  logic [32:0] dec_len33;
  logic [31:0] dec_off32;
  logic [31:0] dec_lit_val;
  logic [2:0]  dec_extra;
  logic        dec_err;
  logic [15:0] dec_lit_pos;

  // Tag decode: type, length (33-bit so overflow is visible), offset, errors
  always_comb begin
    dec_is_copy = 1'b0;
    dec_len33   = 33'd0;
    dec_off32   = 32'd0;
    dec_lit_val = 32'd0;
    dec_extra   = 3'd0;
    dec_err     = 1'b0;
    case (b0[1:0])
      2'b00: begin
        if (tag_n < 6'd60) begin
          dec_len33 = {27'd0, tag_n} + 33'd1;
        end else begin
          // n = 60..63 selects 1..4 little-endian length bytes
          dec_extra = {1'b0, tag_n[1:0]} + 3'd1;
          case (tag_n[1:0])
            2'd0:    dec_lit_val = {24'd0, b1};
            2'd1:    dec_lit_val = {16'd0, b2, b1};
            2'd2:    dec_lit_val = {8'd0, b3, b2, b1};
            default: dec_lit_val = {b4, b3, b2, b1};
          endcase
          dec_len33 = {1'b0, dec_lit_val} + 33'd1;
          dec_err   = (dec_len33 > 33'd65536);
        end
      end
      2'b01: begin
        dec_is_copy = 1'b1;
        dec_len33   = {30'd0, b0[4:2]} + 33'd4;
        dec_off32   = {21'd0, b0[7:5], b1};
      end
      2'b10: begin
        dec_is_copy = 1'b1;
        dec_len33   = {27'd0, tag_n} + 33'd1;
        dec_off32   = {16'd0, b2, b1};
      end
      default: begin
        dec_is_copy = 1'b1;
        dec_len33   = {27'd0, tag_n} + 33'd1;
        dec_off32   = {b4, b3, b2, b1};
        dec_err     = (dec_off32 > 32'd65535);
      end
    endcase
    // A back-reference of distance zero has no meaning
    if (dec_is_copy && (dec_off32 == 32'd0)) begin
      dec_err = 1'b1;
    end
  end

  // Literal bytes start right after the tag and its extra length bytes
  assign dec_lit_pos = dec_is_copy ? 16'd0
                                   : (in_position + 16'd1 + {13'd0, dec_extra});

  // Queue pop and output-slot events
  logic tok_handshake;
  logic pop_tag;
  logic pop_drop;
  logic load_tok;
  logic err_hit;

  assign tok_handshake = tok_valid_q & tok_ready;
  assign in_rdreq      = (state_q == ST_RUN) & in_valid & (~tok_valid_q | tok_ready);
  assign pop_drop      = in_rdreq & in_lit_flag;
  assign pop_tag       = in_rdreq & ~in_lit_flag;
  assign load_tok      = pop_tag & ~dec_err;
  assign err_hit       = pop_tag & dec_err;

  // Next-state: output slot, counters and FSM
  always_comb begin
    state_d       = state_q;
    tok_valid_d   = tok_valid_q;
    tok_is_copy_d = tok_is_copy_q;
    tok_length_d  = tok_length_q;
    tok_offset_d  = tok_offset_q;
    tok_lit_pos_d = tok_lit_pos_q;
    tok_address_d = tok_address_q;
    tok_count_d   = tok_count_q;
    drop_count_d  = drop_count_q;

    if (tok_handshake) begin
      tok_valid_d = 1'b0;
      tok_count_d = tok_count_q + 32'd1;
    end

    if (load_tok) begin
      tok_valid_d   = 1'b1;
      tok_is_copy_d = dec_is_copy;
      tok_length_d  = dec_len33[16:0];
      tok_offset_d  = dec_is_copy ? dec_off32[15:0] : 16'd0;
      tok_lit_pos_d = dec_lit_pos;
      tok_address_d = in_address;
    end

    if (err_hit) begin
      state_d = ST_ERR;
    end

    if (pop_drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      tok_valid_q   <= 1'b0;
      tok_is_copy_q <= 1'b0;
      tok_length_q  <= 17'd0;
      tok_offset_q  <= 16'd0;
      tok_lit_pos_q <= 16'd0;
      tok_address_q <= 17'd0;
      tok_count_q   <= 32'd0;
      drop_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      tok_valid_q   <= tok_valid_d;
      tok_is_copy_q <= tok_is_copy_d;
      tok_length_q  <= tok_length_d;
      tok_offset_q  <= tok_offset_d;
      tok_lit_pos_q <= tok_lit_pos_d;
      tok_address_q <= tok_address_d;
      tok_count_q   <= tok_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign tok_valid   = tok_valid_q;
  assign tok_is_copy = tok_is_copy_q;
  assign tok_length  = tok_length_q;
  assign tok_offset  = tok_offset_q;
  assign tok_lit_pos = tok_lit_pos_q;
  assign tok_address = tok_address_q;
  assign tok_count   = tok_count_q;
  assign drop_count  = drop_count_q;
  assign err         = (state_q == ST_ERR);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_token_decoder.sv
// Bench for token_decoder: a show-ahead input queue, a reference decoder
// written from the Snappy tag rules, and an expected-token queue.
module tb_token_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [143:0] in_data = '0;
  logic [15:0]  in_position = '0;
  logic [16:0]  in_address = '0;
  logic [1:0]   in_garbage = '0;
  logic         in_lit_flag = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_rdreq;
  logic         tok_valid;
  logic         tok_ready = 1'b0;
  logic         tok_is_copy;
  logic [16:0]  tok_length;
  logic [15:0]  tok_offset;
  logic [15:0]  tok_lit_pos;
  logic [16:0]  tok_address;
  logic [31:0]  tok_count;
  logic [15:0]  drop_count;
  logic         err;
  logic         state_dbg;

  token_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_position(in_position), .in_address(in_address),
    .in_garbage(in_garbage), .in_lit_flag(in_lit_flag), .in_valid(in_valid),
    .in_rdreq(in_rdreq),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_copy(tok_is_copy),
    .tok_length(tok_length), .tok_offset(tok_offset), .tok_lit_pos(tok_lit_pos),
    .tok_address(tok_address), .tok_count(tok_count), .drop_count(drop_count),
    .err(err), .state_dbg(state_dbg)
  );

  // ---------------- bench state ----------------
  typedef struct {
    logic [143:0] data;
    logic [15:0]  pos;
    logic [16:0]  addr;
    logic         lit;
  } entry_t;

  entry_t      in_q[$];
  logic [66:0] exp_q[$];   // {is_copy, length, offset, lit_pos, address}

  int          n_cmp = 0;
  int          n_mis = 0;
  int          ready_pct = 100;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_cnt = '0;
  int          exp_drops = 0;
  logic        err_exp = 1'b0;

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the tag rules, using integer arithmetic.
  function automatic void ref_decode(input entry_t e, output logic [66:0] tok, output bit bad);
    longint b[5];
    longint t, typ, n, extra, val, len, off, lpos;
    for (int k = 0; k < 5; k++) b[k] = longint'(e.data[143-8*k -: 8]);
    t = b[0]; typ = t % 4; n = t / 4;
    extra = 0; off = 0; len = 0; bad = 0;
    case (typ)
      0: begin
        if (n < 60) len = n + 1;
        else begin
          extra = n - 59;
          val = 0;
          for (int k = 0; k < 4; k++) if (k < extra) val = val + (b[1+k] << (8*k));
          len = val + 1;
        end
        bad = (len > 65536);
      end
      1: begin len = (n % 8) + 4; off = (t / 32) * 256 + b[1]; end
      2: begin len = n + 1;       off = b[2] * 256 + b[1]; end
      default: begin
        len = n + 1;
        off = (b[4] << 24) + (b[3] << 16) + (b[2] << 8) + b[1];
        if (off > 65535) bad = 1;
      end
    endcase
    if (typ != 0 && off == 0) bad = 1;
    lpos = (typ == 0) ? (longint'(e.pos) + 1 + extra) % 65536 : 0;
    tok = {(typ != 0), 17'(len), 16'(off), 16'(lpos), e.addr};
  endfunction

  function automatic entry_t mk(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                                input logic [7:0] t3, input logic [7:0] t4,
                                input logic [15:0] pos, input logic [16:0] addr);
    entry_t e;
    e.data = {t0, t1, t2, t3, t4, 104'd0};
    e.pos = pos; e.addr = addr; e.lit = 1'b0;
    return e;
  endfunction

  function automatic entry_t gen_entry();
    entry_t e;
    logic [159:0] r;
    int typ, n;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e.data = r[143:0];
    e.pos  = ($urandom_range(4) == 0) ? 16'hFFFE : 16'($urandom);
    e.addr = 17'($urandom);
    e.lit  = ($urandom_range(7) == 0);
    typ = $urandom_range(3);
    n   = $urandom_range(63);
    e.data[143:136] = 8'(n * 4 + typ);
    case (typ)
      0: begin
        if (n >= 62) e.data[119:112] = 8'd0;
        if (n == 63) e.data[111:104] = 8'd0;
        if (n == 61 && $urandom_range(3) == 0) e.data[135:120] = 16'hFFFF;
      end
      1: if (e.data[135:128] == 8'd0 && (n / 8) == 0) e.data[135:128] = 8'd1;
      2: if (e.data[135:120] == 16'd0) e.data[135:128] = 8'd1;
      default: begin
        e.data[119:104] = 16'd0;
        if (e.data[135:120] == 16'd0) e.data[135:128] = 8'd1;
      end
    endcase
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_entry(input entry_t e);
    logic [66:0] tok;
    bit bad;
    in_q.push_back(e);
    if (!e.lit) begin
      ref_decode(e, tok, bad);
      if (!bad) exp_q.push_back(tok);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((in_q.size() > 0 || tok_valid || exp_q.size() > 0) && k < 2000) begin
      step();
      k++;
    end
    check("drain_timeout", 67'(k < 2000), 67'(1));
  endtask

  // Queue/model update at each edge, then present the new head and tok_ready
  entry_t      pe;
  logic [66:0] ptok;
  bit          pbad;
  logic        d_hs, d_load;
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_valid = 1'b0; exp_cnt = '0; exp_drops = 0; err_exp = 1'b0;
      in_q.delete(); exp_q.delete();
    end else begin
      d_hs = exp_valid && tok_ready;
      d_load = 1'b0;
      if (in_rdreq && in_q.size() > 0) begin
        pe = in_q.pop_front();
        if (pe.lit) begin
          if (exp_drops < 65535) exp_drops++;
        end else begin
          ref_decode(pe, ptok, pbad);
          if (pbad) err_exp = 1'b1;
          else d_load = 1'b1;
        end
      end
      if (d_hs) begin
        exp_cnt = exp_cnt + 32'd1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      exp_valid = d_load || (exp_valid && !tok_ready);
    end
    #1;
    if (in_q.size() > 0) begin
      in_valid = 1'b1; in_data = in_q[0].data; in_position = in_q[0].pos;
      in_address = in_q[0].addr; in_lit_flag = in_q[0].lit;
      in_garbage = 2'($urandom);
    end else begin
      in_valid = 1'b0; in_data = '0; in_position = '0; in_address = '0; in_lit_flag = 1'b0;
    end
    tok_ready = ($urandom_range(99) < ready_pct);
  end

  // ---------------- scoreboard (sampled on falling edge) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("tok_valid", 67'(tok_valid), 67'(exp_valid));
      check("err", 67'(err), 67'(err_exp));
      check("state_dbg", 67'(state_dbg), 67'(err_exp));
      check("in_rdreq", 67'(in_rdreq), 67'(in_valid && (!exp_valid || tok_ready) && !err_exp));
      check("tok_count", 67'(tok_count), 67'(exp_cnt));
      check("drop_count", 67'(drop_count), 67'(exp_drops));
      if (tok_valid && exp_q.size() > 0)
        check("tok_fields", {tok_is_copy, tok_length, tok_offset, tok_lit_pos, tok_address}, exp_q[0]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  int cnt_snap;
  initial begin
    // reset
    ready_pct = 100;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_tok_valid", 67'(tok_valid), 67'(0));
    check("rst_err", 67'(err), 67'(0));
    check("rst_tok_count", 67'(tok_count), 67'(0));
    check("rst_drop_count", 67'(drop_count), 67'(0));
    check("rst_fields", {tok_is_copy, tok_length, tok_offset, tok_lit_pos, tok_address}, 67'(0));
    step();

    // short literal
    push_entry(mk(8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0010, 17'h00100));
    step(); step();
    check("lit_fields", {tok_is_copy, tok_length, tok_lit_pos, tok_address},
          {1'b0, 17'd4, 16'h0011, 17'h00100});
    step();
    check("lit_tok_count", 67'(tok_count), 67'(1));

    // long literal, one extra length byte
    push_entry(mk(8'hF0, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h0100, 17'h00200));
    step(); step();
    check("longlit_fields", {tok_is_copy, tok_length, tok_lit_pos}, {1'b0, 17'd256, 16'h0102});
    step();

    // copy1 then copy2 back to back
    push_entry(mk(8'h2D, 8'h10, 8'h00, 8'h00, 8'h00, 16'h0200, 17'h00300));
    push_entry(mk(8'h0A, 8'h34, 8'h12, 8'h00, 8'h00, 16'h0202, 17'h00307));
    step(); step();
    check("copy1_fields", {tok_is_copy, tok_length, tok_offset}, {1'b1, 17'd7, 16'h0110});
    check("copy1_rdreq", 67'(in_rdreq), 67'(1));
    step();
    check("copy2_fields", {tok_is_copy, tok_length, tok_offset, tok_lit_pos}, {1'b1, 17'd3, 16'h1234, 16'h0});
    drain();

    // backpressure: output stalls, queue must not be popped
    ready_pct = 0;
    step(); step();
    push_entry(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0300, 17'h00400));
    push_entry(mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0302, 17'h00401));
    push_entry(mk(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0305, 17'h00403));
    repeat (5) step();
    check("bp_rdreq", 67'(in_rdreq), 67'(0));
    check("bp_valid", 67'(tok_valid), 67'(1));
    check("bp_length", 67'(tok_length), 67'(1));
    ready_pct = 100;
    drain();
    check("bp_tok_count", 67'(tok_count), 67'(7));

    // literal continuation entry between two tags is dropped
    begin
      entry_t e;
      push_entry(mk(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0400, 17'h00500));
      e = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0405, 17'h00505);
      e.lit = 1'b1;
      push_entry(e);
      push_entry(mk(8'h05, 8'h20, 8'h00, 8'h00, 8'h00, 16'h0406, 17'h00505));
    end
    drain();
    check("drop_count_one", 67'(drop_count), 67'(1));
    check("drop_tok_count", 67'(tok_count), 67'(9));

    // random traffic with random backpressure
    ready_pct = 70;
    for (int i = 0; i < 400; i++) begin
      step();
      if (in_q.size() < 6) begin
        for (int j = 0; j < $urandom_range(2); j++) push_entry(gen_entry());
      end
    end
    ready_pct = 100;
    drain();

    // copy1 with zero offset: error, then nothing more moves
    push_entry(mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0500, 17'h00600));
    repeat (4) step();
    check("err1_err", 67'(err), 67'(1));
    check("err1_state", 67'(state_dbg), 67'(1));
    cnt_snap = int'(exp_cnt);
    push_entry(mk(8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0510, 17'h00610));
    repeat (5) step();
    check("err1_rdreq", 67'(in_rdreq), 67'(0));
    check("err1_no_tok", 67'(tok_valid), 67'(0));
    check("err1_count_frozen", 67'(tok_count), 67'(cnt_snap));
    check("err1_not_popped", 67'(in_q.size()), 67'(1));

    // reset clears everything
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_count", 67'(tok_count), 67'(0));
    check("rst2_drops", 67'(drop_count), 67'(0));
    check("rst2_err", 67'(err), 67'(0));
    step();

    // copy4 with offset above 65535
    push_entry(mk(8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 16'h0600, 17'h00700));
    repeat (4) step();
    check("err4_err", 67'(err), 67'(1));
    check("err4_rdreq", 67'(in_rdreq), 67'(0));

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    push_entry(mk(8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0010, 17'h00100));
    drain();
    check("resume_count", 67'(tok_count), 67'(1));

    // reset mid-stream discards a held token
    ready_pct = 0;
    step(); step();
    push_entry(mk(8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0020, 17'h00120));
    repeat (4) step();
    check("mid_valid_before", 67'(tok_valid), 67'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_valid_after", 67'(tok_valid), 67'(0));
    check("mid_length_after", 67'(tok_length), 67'(0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/token_decoder.md
# token_decoder

Consumes Snappy token entries from the token queue and decodes each tag byte into one literal or copy command for the downstream literal/copy engines. Pops one queue entry per cycle when the output slot is free, decodes tag type, length and offset with extra-byte handling, and registers the result behind a valid/ready handshake. A malformed or unsupported tag halts the block in an error state until reset.

## Interface

- No parameters.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  144  18-byte window; byte i = in_data[143-8i -: 8]; byte 0 is the tag byte.
- in_position  in  16  compressed-stream byte position of byte 0.
- in_address  in  17  uncompressed output address where this token's output starts.
- in_garbage  in  2  ignored.
- in_lit_flag  in  1  1 = entry is literal continuation, no tag; consume and drop.
- in_valid  in  1  queue head is valid.
- in_rdreq  out  1  pop strobe; new head is visible on in_valid one cycle later.
- tok_valid  out  1  decoded token present.
- tok_ready  in  1  downstream accepts the token when tok_valid & tok_ready.
- tok_is_copy  out  1  0 = literal, 1 = copy.
- tok_length  out  17  byte count, range 1..65536.
- tok_offset  out  16  copy back-distance; 0 for literals.
- tok_lit_pos  out  16  literals: in_position + 1 + extra length bytes; copies: 0.
- tok_address  out  17  registered in_address.
- tok_count  out  32  tokens emitted since reset.
- drop_count  out  16  lit_flag entries dropped, saturating at 0xFFFF.
- err  out  1  sticky error.

## Operation

- States: RUN, ERR. Reset enters RUN.
- RUN: in_rdreq = in_valid & (~tok_valid | tok_ready). This path is combinational, so a full output slot drains and refills in the same cycle. ERR: in_rdreq = 0.
- On each pop with in_lit_flag = 1: no token is produced; drop_count increments.
- On each pop with in_lit_flag = 0, decode with t = byte0 and tag type t[1:0]:
  - 00 literal, n = t[7:2]:
    - n < 60: length = n + 1, extra = 0.
    - n = 60..63: extra = n − 59 bytes, little-endian from byte1; length = value + 1.
    - extra = 3 or 4 with value + 1 > 65536: error.
  - 01 copy1: length = t[4:2] + 4; offset = {t[7:5], byte1}.
  - 10 copy2: length = t[7:2] + 1; offset = {byte2, byte1}.
  - 11 copy4: offset = {byte4..byte1}. Offset > 65535 is an error; otherwise use the low 16 bits and length = t[7:2] + 1.
  - A copy with offset = 0 is an error.
- Decoded fields load into the output register and tok_valid is set. tok_valid clears on a handshake unless a new pop reloads it in the same cycle.
- tok_count increments on each tok_valid & tok_ready. It wraps at 2^32.
- On error: no token is loaded, err is set, state goes to ERR. A token already in the output register still drains normally.
- Arithmetic: lengths are computed in 33 bits, then range-checked; tok_lit_pos wraps modulo 2^16.

## Timing

- Reset values: tok_valid = 0, err = 0, tok_count = 0, drop_count = 0; all data outputs 0; state = RUN.
- Latency: a pop in cycle N gives tok_valid = 1 in cycle N+1.
- Throughput: one token per cycle while tok_ready stays high.
- tok_ready low with tok_valid high: in_rdreq = 0, output fields are held stable.
- in_valid low: in_rdreq = 0; tok_valid keeps draining.
- Handshake and pop in the same cycle: the new token replaces the old one with no bubble.
- Reset asserted mid-stream discards the output token; the upstream queue is reset separately.

## Test plan

- Literal: byte0 = 0x0C, position 0x0010, address 0x00100 → 1 cycle later: is_copy 0, length 4, lit_pos 0x0011, address 0x00100; tok_count = 1 after handshake.
- Long literal: byte0 = 0xF0 (n = 60), byte1 = 0xFF → length 256, lit_pos = position + 2.
- Copy1 / copy2 back-to-back with tok_ready held high:
  - 0x2D, 0x10 → copy1, length 7, offset 0x110.
  - 0x0A, 0x34, 0x12 → copy2, length 3, offset 0x1234.
  - Both emitted on consecutive cycles with in_rdreq high both cycles.
- Backpressure: tok_ready low for 5 cycles with in_valid high → in_rdreq = 0 and outputs stable; on release, one handshake per cycle.
- lit_flag = 1 entry between two tags → drop_count = 1, exactly 2 tokens emitted.
- Errors:
  - copy1 0x01, 0x00 (offset 0) → err = 1, state ERR, in_rdreq stuck at 0, no new tokens.
  - copy4 with byte3 = 0x01 (offset > 65535) → the same response.
  - After rst_n low for one cycle, all counters are 0 and decoding resumes.
